// File: rtl/i2c_target_os.sv
// I2C target engine clocked entirely from clk_50M: oversampled SCL/SDA, glitch filter,
// START/STOP detection and a byte FSM driving an external register bank via strobes.
module i2c_target_os #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         REG_AW   = 4,
    parameter int         FILT_LEN = 3,
    parameter int         SDA_HOLD = 10
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        H_NONE = 2'd0,
        H_ACK  = 2'd1,
        H_REL  = 2'd2,
        H_DATA = 2'd3
    } hold_t;

    localparam int               HW        = (SDA_HOLD < 4) ? 2 : $clog2(SDA_HOLD);
    localparam logic [HW-1:0]    HOLD_INIT = HW'(SDA_HOLD - 1);
    localparam logic [3:0]       FILT_MAX  = 4'(FILT_LEN - 1);
    localparam logic [REG_AW-1:0] PTR_ONE  = REG_AW'(1);

    state_t            state_q, state_d;
    hold_t             hold_req, hold_act;
    logic [HW-1:0]     hold_cnt;
    logic [1:0]        scl_sync, sda_sync;
    logic [3:0]        scl_cnt, sda_cnt;
    logic              scl_filt, sda_filt, scl_prev, sda_prev;
    logic              scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]        shift, tx, byte_now;
    logic [2:0]        bit_cnt;
    logic [REG_AW-1:0] ptr;
    logic              ack_seen, rd_d1;
    logic              byte_state, ack_state, last_bit;
    logic              rd_req, wr_req, ptr_load;

    // Two-stage synchroniser, then a line only flips after FILT_LEN agreeing samples.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            scl_cnt  <= 4'd0;
            sda_cnt  <= 4'd0;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_prev <= scl_filt;
            sda_prev <= sda_filt;
            if (scl_sync[1] == scl_filt) begin
                scl_cnt <= 4'd0;
            end else if (scl_cnt == FILT_MAX) begin
                scl_filt <= scl_sync[1];
                scl_cnt  <= 4'd0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
            if (sda_sync[1] == sda_filt) begin
                sda_cnt <= 4'd0;
            end else if (sda_cnt == FILT_MAX) begin
                sda_filt <= sda_sync[1];
                sda_cnt  <= 4'd0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
        end
    end

    assign scl_rise   = scl_filt & ~scl_prev;
    assign scl_fall   = ~scl_filt & scl_prev;
    assign start_det  = scl_filt & scl_prev & sda_prev & ~sda_filt;
    assign stop_det   = scl_filt & scl_prev & ~sda_prev & sda_filt;
    assign byte_now   = {shift[6:0], sda_filt};
    assign byte_state = (state_q == ADDR) || (state_q == PTR) ||
                        (state_q == WDATA) || (state_q == RDATA);
    assign ack_state  = (state_q == ADDR_ACK) || (state_q == PTR_ACK) ||
                        (state_q == WDATA_ACK) || (state_q == RDATA_ACK);
    assign last_bit   = scl_rise && byte_state && (bit_cnt == 3'd7);

    always_ff @(posedge clk_50M) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // In ACK states the first SCL fall starts the ACK bit; the fall after its rise ends it.
    always_comb begin
        state_d  = state_q;
        hold_req = H_NONE;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        ptr_load = 1'b0;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = ADDR;
        end else begin
            case (state_q)
                ADDR: begin
                    if (last_bit)
                        state_d = (byte_now[7:1] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_seen) begin
                            hold_req = H_ACK;
                        end else if (shift[0]) begin
                            state_d  = RDATA;
                            rd_req   = 1'b1;
                            hold_req = H_DATA;
                        end else begin
                            state_d  = PTR;
                            hold_req = H_REL;
                        end
                    end
                end
                PTR: begin
                    if (last_bit) begin
                        state_d  = PTR_ACK;
                        ptr_load = 1'b1;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_seen) begin
                            hold_req = H_ACK;
                        end else begin
                            state_d  = WDATA;
                            hold_req = H_REL;
                        end
                    end
                end
                WDATA: begin
                    if (last_bit) begin
                        state_d = WDATA_ACK;
                        wr_req  = 1'b1;
                    end
                end
                RDATA: begin
                    if (last_bit)      state_d  = RDATA_ACK;
                    else if (scl_fall) hold_req = H_DATA;
                end
                RDATA_ACK: begin
                    if (scl_rise && sda_filt) begin
                        state_d = WAIT_STOP;
                    end else if (scl_fall) begin
                        if (!ack_seen) begin
                            hold_req = H_REL;
                        end else begin
                            state_d  = RDATA;
                            rd_req   = 1'b1;
                            hold_req = H_DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: shifting, strobes, pointer and the delayed SDA drive.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            shift     <= 8'd0;
            tx        <= 8'd0;
            bit_cnt   <= 3'd0;
            ptr       <= '0;
            reg_wdata <= 8'd0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            rd_d1     <= 1'b0;
            ack_seen  <= 1'b0;
            sda_oe    <= 1'b0;
            hold_act  <= H_NONE;
            hold_cnt  <= '0;
        end else begin
            reg_wr <= wr_req;
            reg_rd <= rd_req;
            rd_d1  <= reg_rd;
            if (wr_req) reg_wdata <= byte_now;

            if (start_det) begin
                bit_cnt <= 3'd0;
            end else if (scl_rise && byte_state) begin
                shift   <= byte_now;
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (rd_d1)                                   tx <= reg_rdata;
            else if (scl_rise && (state_q == RDATA))     tx <= {tx[6:0], 1'b0};

            if (ptr_load)             ptr <= byte_now[REG_AW-1:0];
            else if (reg_wr || rd_d1) ptr <= ptr + PTR_ONE;

            if (state_d != state_q)          ack_seen <= 1'b0;
            else if (scl_rise && ack_state)  ack_seen <= 1'b1;

            // START/STOP cancel any scheduled drive change and free the line at once.
            if (start_det || stop_det) begin
                hold_act <= H_NONE;
                sda_oe   <= 1'b0;
            end else if (hold_req != H_NONE) begin
                hold_act <= hold_req;
                hold_cnt <= HOLD_INIT;
            end else if (hold_act != H_NONE) begin
                if (hold_cnt == '0) begin
                    hold_act <= H_NONE;
                    case (hold_act)
                        H_ACK:   sda_oe <= 1'b1;
                        H_REL:   sda_oe <= 1'b0;
                        H_DATA:  sda_oe <= ~(rd_d1 ? reg_rdata[7] : tx[7]);
                        default: sda_oe <= 1'b0;
                    endcase
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end
        end
    end

    assign reg_addr = ptr;
    assign busy     = (state_q != IDLE);
    assign state    = state_q;

endmodule

// File: tb/tb_i2c_target_os.sv
// Directed bench for i2c_target_os: bit-banged I2C master, open-drain SDA model and
// a small register bank; strobes are logged and compared against hand-computed values.
module tb_i2c_target_os;

    logic       clk_50M = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    logic [3:0] state;

    logic       bank_init;
    logic [7:0] bank [0:15];
    logic [3:0] wr_addr_log [0:15];
    logic [7:0] wr_data_log [0:15];
    logic [3:0] rd_addr_log [0:15];
    int         wr_count = 0;
    int         rd_count = 0;
    int         oe_cycles = 0;
    int         busy_cycles = 0;
    int         both_cycles = 0;
    int         checks = 0;
    int         errors = 0;

    i2c_target_os #(
        .DEV_ADDR(7'h50),
        .REG_AW  (4),
        .FILT_LEN(3),
        .SDA_HOLD(10)
    ) dut (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wr   (reg_wr),
        .reg_rd   (reg_rd),
        .reg_rdata(reg_rdata),
        .busy     (busy),
        .state    (state)
    );

    always #10 clk_50M = ~clk_50M;

    // Open-drain bus: either side can pull SDA low.
    assign sda_line = sda_m & ~sda_oe;

    always @(posedge clk_50M) begin
        if (bank_init) begin
            for (int i = 0; i < 16; i++) bank[i] <= 8'h00;
            bank[5] <= 8'hC3;
        end else if (reg_wr) begin
            bank[reg_addr] <= reg_wdata;
        end
        if (reg_rd) reg_rdata <= bank[reg_addr];
    end

    always @(posedge clk_50M) begin
        if (sda_oe) oe_cycles++;
        if (busy) busy_cycles++;
        if (reg_wr && reg_rd) both_cycles++;
        if (reg_wr) begin
            if (wr_count < 16) begin
                wr_addr_log[wr_count] = reg_addr;
                wr_data_log[wr_count] = reg_wdata;
            end
            wr_count++;
        end
        if (reg_rd) begin
            if (rd_count < 16) rd_addr_log[rd_count] = reg_addr;
            rd_count++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Each bit starts just after SCL fell: SDA set mid-low, SCL high for 40 cycles.
    task automatic send_bit(input logic b, input logic glitch);
        wait_cycles(20); sda_m = b;
        wait_cycles(20); scl = 1'b1;
        if (glitch) begin
            wait_cycles(10); scl = 1'b0;
            wait_cycles(2);  scl = 1'b1;
            wait_cycles(10); sda_m = 1'b0;
            wait_cycles(2);  sda_m = b;
            wait_cycles(16);
        end else begin
            wait_cycles(40);
        end
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic glitch, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch && (i == 7));
        wait_cycles(20); sda_m = 1'b1;
        wait_cycles(20); scl = 1'b1;
        wait_cycles(20); ack = sda_oe;
        wait_cycles(20); scl = 1'b0;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            wait_cycles(20); sda_m = 1'b1;
            wait_cycles(20); scl = 1'b1;
            wait_cycles(20); b[i] = sda_line;
            wait_cycles(20); scl = 1'b0;
        end
        wait_cycles(20); sda_m = ~master_ack;
        wait_cycles(20); scl = 1'b1;
        wait_cycles(40); scl = 1'b0;
    endtask

    task automatic i2c_start;
        sda_m = 1'b0;
        wait_cycles(40); scl = 1'b0;
    endtask

    task automatic i2c_rstart;
        wait_cycles(20); sda_m = 1'b1;
        wait_cycles(20); scl = 1'b1;
        wait_cycles(40); sda_m = 1'b0;
        wait_cycles(40); scl = 1'b0;
    endtask

    task automatic i2c_stop;
        wait_cycles(20); sda_m = 1'b0;
        wait_cycles(20); scl = 1'b1;
        wait_cycles(40); sda_m = 1'b1;
        wait_cycles(40);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         snap;

        rst = 1'b1; scl = 1'b1; sda_m = 1'b1; bank_init = 1'b1;
        wait_cycles(5);
        check_output("reset_state", state, 0);
        check_output("reset_sda_oe", sda_oe, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_reg_addr", reg_addr, 0);
        check_output("reset_strobes", {reg_wr, reg_rd}, 0);
        rst = 1'b0; bank_init = 1'b0;
        wait_cycles(20);

        $display("[TB] write 0xA0 0x03 0xA5 0x5A");
        i2c_start;
        check_output("start_state", state, 1);
        write_byte(8'hA0, 1'b0, ack); check_output("wr_addr_ack", ack, 1);
        write_byte(8'h03, 1'b0, ack); check_output("wr_ptr_ack", ack, 1);
        write_byte(8'hA5, 1'b0, ack); check_output("wr_d0_ack", ack, 1);
        write_byte(8'h5A, 1'b0, ack); check_output("wr_d1_ack", ack, 1);
        check_output("wr_busy_before_stop", busy, 1);
        i2c_stop;
        check_output("wr_busy_after_stop", busy, 0);
        check_output("wr_count", wr_count, 2);
        check_output("wr0_addr", wr_addr_log[0], 4'h3);
        check_output("wr0_data", wr_data_log[0], 8'hA5);
        check_output("wr1_addr", wr_addr_log[1], 4'h4);
        check_output("wr1_data", wr_data_log[1], 8'h5A);

        $display("[TB] read with repeated start");
        i2c_start;
        write_byte(8'hA0, 1'b0, ack); check_output("rd_waddr_ack", ack, 1);
        write_byte(8'h04, 1'b0, ack); check_output("rd_ptr_ack", ack, 1);
        i2c_rstart;
        write_byte(8'hA1, 1'b0, ack); check_output("rd_raddr_ack", ack, 1);
        read_byte(1'b1, d); check_output("rd_byte0", d, 8'h5A);
        read_byte(1'b0, d); check_output("rd_byte1", d, 8'hC3);
        check_output("rd_state_after_nack", state, 9);
        i2c_stop;
        check_output("rd_state_after_stop", state, 0);
        check_output("rd_count", rd_count, 2);
        check_output("rd0_addr", rd_addr_log[0], 4'h4);
        check_output("rd1_addr", rd_addr_log[1], 4'h5);
        check_output("rd_no_writes", wr_count, 2);

        $display("[TB] address mismatch");
        snap = oe_cycles;
        i2c_start;
        write_byte(8'hA2, 1'b0, ack); check_output("mm_no_ack", ack, 0);
        check_output("mm_state_wait", state, 9);
        i2c_stop;
        check_output("mm_state_idle", state, 0);
        check_output("mm_oe_never", oe_cycles - snap, 0);
        check_output("mm_no_strobes", wr_count + rd_count, 4);

        $display("[TB] pointer wrap");
        i2c_start;
        write_byte(8'hA0, 1'b0, ack);
        write_byte(8'h0F, 1'b0, ack);
        write_byte(8'h11, 1'b0, ack);
        write_byte(8'h22, 1'b0, ack); check_output("wrap_ack", ack, 1);
        i2c_stop;
        i2c_start;
        write_byte(8'hA0, 1'b0, ack);
        write_byte(8'hFF, 1'b0, ack); check_output("wrap_ptr_ff_ack", ack, 1);
        write_byte(8'h33, 1'b0, ack);
        i2c_stop;
        check_output("wrap_count", wr_count, 5);
        check_output("wrap0_addr", wr_addr_log[2], 4'hF);
        check_output("wrap0_data", wr_data_log[2], 8'h11);
        check_output("wrap1_addr", wr_addr_log[3], 4'h0);
        check_output("wrap1_data", wr_data_log[3], 8'h22);
        check_output("wrap_ff_addr", wr_addr_log[4], 4'hF);
        check_output("wrap_ff_data", wr_data_log[4], 8'h33);
        check_output("wrap_ptr_after", reg_addr, 4'h0);

        $display("[TB] glitch filter");
        snap = busy_cycles;
        sda_m = 1'b0; wait_cycles(2); sda_m = 1'b1; wait_cycles(20);
        scl = 1'b0;   wait_cycles(2); scl = 1'b1;   wait_cycles(20);
        check_output("glitch_2cyc_ignored", busy_cycles - snap, 0);
        sda_m = 1'b0; wait_cycles(3); sda_m = 1'b1; wait_cycles(20);
        check_output("glitch_3cyc_detected", busy_cycles > snap, 1);
        check_output("glitch_3cyc_stop_idle", state, 0);
        i2c_start;
        write_byte(8'hA0, 1'b1, ack); check_output("glitch_addr_ack", ack, 1);
        write_byte(8'h07, 1'b0, ack);
        write_byte(8'h44, 1'b0, ack); check_output("glitch_data_ack", ack, 1);
        i2c_stop;
        check_output("glitch_wr_count", wr_count, 6);
        check_output("glitch_wr_addr", wr_addr_log[5], 4'h7);
        check_output("glitch_wr_data", wr_data_log[5], 8'h44);

        $display("[TB] reset during read");
        i2c_start;
        write_byte(8'hA1, 1'b0, ack); check_output("rst_raddr_ack", ack, 1);
        wait_cycles(30);
        check_output("rst_driving_zero", sda_oe, 1);
        rst = 1'b1;
        wait_cycles(1);
        check_output("rst_mid_sda_oe", sda_oe, 0);
        check_output("rst_mid_state", state, 0);
        check_output("rst_mid_ptr", reg_addr, 0);
        rst = 1'b0;
        sda_m = 1'b1;
        wait_cycles(20); scl = 1'b1;
        wait_cycles(60);
        i2c_start;
        write_byte(8'hA0, 1'b0, ack); check_output("post_rst_addr_ack", ack, 1);
        write_byte(8'h00, 1'b0, ack); check_output("post_rst_ptr_ack", ack, 1);
        write_byte(8'h77, 1'b0, ack); check_output("post_rst_data_ack", ack, 1);
        i2c_stop;
        check_output("post_rst_wr_addr", wr_addr_log[6], 4'h0);
        check_output("post_rst_wr_data", wr_data_log[6], 8'h77);
        check_output("post_rst_idle", state, 0);
        check_output("no_wr_rd_overlap", both_cycles, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
